// File: rtl/i2s_pkg.sv
// Shared types for the I2S transmit path: sample word, stereo pair and packer state.
package i2s_pkg;

  typedef logic [31:0] i2s_sample_t;

  typedef struct packed {
    i2s_sample_t l;
    i2s_sample_t r;
  } i2s_pair_t;

  typedef enum logic {
    PK_LEFT  = 1'b0,
    PK_RIGHT = 1'b1
  } pk_state_t;

endpackage

// File: rtl/i2s_tx_fifo_if.sv
// Register-side and transmitter-side signals of the stereo sample FIFO.
interface i2s_tx_fifo_if #(
  parameter int DEPTH = 8
);

  logic                     flush;
  logic                     wr_en;
  logic [31:0]              wr_data;
  logic                     data_rqst;
  logic                     err_clr;
  logic [31:0]              data_left;
  logic [31:0]              data_right;
  logic [$clog2(DEPTH):0]   level;
  logic                     full;
  logic                     empty;
  logic                     low_wm;
  logic                     overflow;
  logic                     underrun;

  modport master (
    output flush, wr_en, wr_data, data_rqst, err_clr,
    input  data_left, data_right, level, full, empty, low_wm, overflow, underrun
  );

  modport slave (
    input  flush, wr_en, wr_data, data_rqst, err_clr,
    output data_left, data_right, level, full, empty, low_wm, overflow, underrun
  );

endinterface

// File: rtl/i2s_pair_ram.sv
// Stereo-pair storage: one synchronous write port, one asynchronous read port.
module i2s_pair_ram
  import i2s_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  i2s_pair_t       i_wdata,
  input  logic [AW-1:0]   i_raddr,
  output i2s_pair_t       o_rdata
);

  i2s_pair_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/i2s_tx_fifo.sv
// Packs register writes into left/right pairs and hands one pair per frame to the I2S transmitter.
module i2s_tx_fifo
  import i2s_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int LOW_WM  = 2,
  parameter bit MUTE_UR = 1'b1
) (
  input logic          clk,
  input logic          rst,
  i2s_tx_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  pk_state_t   r_pk_state;
  i2s_sample_t r_hold;
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  i2s_pair_t   r_out;
  logic        r_overflow;
  logic        r_underrun;

  logic [AW:0] w_level;
  logic        w_full;
  logic        w_empty;
  logic        w_commit;
  logic        w_pop;
  logic        w_pop_ok;
  logic        w_accept;
  logic        w_ovf_set;
  logic        w_ur_set;
  i2s_pair_t   w_head;
  i2s_pair_t   w_wpair;

  assign w_level  = r_wr_ptr - r_rd_ptr;
  assign w_full   = (w_level == (AW+1)'(DEPTH));
  assign w_empty  = (w_level == '0);

  assign w_commit = bus.wr_en && (r_pk_state == PK_RIGHT) && !bus.flush;
  assign w_pop    = bus.data_rqst && !bus.flush;
  assign w_pop_ok = w_pop && !w_empty;
  // A pop in the same cycle frees the slot, so a commit while full is still accepted.
  assign w_accept  = w_commit && (!w_full || w_pop_ok);
  assign w_ovf_set = w_commit && w_full && !w_pop_ok;
  assign w_ur_set  = w_pop && w_empty;
  assign w_wpair   = '{l: r_hold, r: bus.wr_data};

  i2s_pair_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (w_wpair),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pk_state <= PK_LEFT;
      r_hold     <= '0;
    end else if (bus.flush) begin
      r_pk_state <= PK_LEFT;
      r_hold     <= '0;
    end else if (bus.wr_en) begin
      case (r_pk_state)
        PK_LEFT: begin
          r_hold     <= bus.wr_data;
          r_pk_state <= PK_RIGHT;
        end
        PK_RIGHT: r_pk_state <= PK_LEFT;
        default:  r_pk_state <= PK_LEFT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // On underrun the outputs either mute or keep presenting the last pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else if (bus.flush) begin
      r_out <= '0;
    end else if (w_pop_ok) begin
      r_out <= w_head;
    end else if (w_ur_set && MUTE_UR) begin
      r_out <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_overflow <= w_ovf_set || (r_overflow && !bus.err_clr);
      r_underrun <= w_ur_set  || (r_underrun && !bus.err_clr);
    end
  end

  assign bus.data_left  = r_out.l;
  assign bus.data_right = r_out.r;
  assign bus.level      = w_level;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.low_wm     = (w_level <= (AW+1)'(LOW_WM));
  assign bus.overflow   = r_overflow;
  assign bus.underrun   = r_underrun;

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Directed and scoreboard checks of i2s_tx_fifo; a muting and a repeating instance run side by side.
module tb_i2s_tx_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2s_tx_fifo_if #(.DEPTH(8)) bus0 ();
  i2s_tx_fifo_if #(.DEPTH(8)) bus1 ();

  i2s_tx_fifo #(.DEPTH(8), .LOW_WM(2), .MUTE_UR(1'b1)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  i2s_tx_fifo #(.DEPTH(8), .LOW_WM(2), .MUTE_UR(1'b0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  typedef enum logic [1:0] {OP_NOP, OP_WR, OP_RQ} op_t;

  typedef struct {
    op_t         op;
    logic [31:0] data;
    logic [3:0]  expLevel;
    logic        expEmpty;
    logic        expLowWm;
    logic        chkData;
    logic [31:0] expLeft;
    logic [31:0] expRight;
  } vec_t;

  int compared   = 0;
  int mismatched = 0;
  logic [63:0] sbQ[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives both instances for one clock, then leaves the bench 1 ns past the edge.
  task automatic applyStimulus(input logic wr, input logic [31:0] d, input logic rq,
                               input logic fl, input logic ec);
    bus0.wr_en = wr; bus0.wr_data = d; bus0.data_rqst = rq; bus0.flush = fl; bus0.err_clr = ec;
    bus1.wr_en = wr; bus1.wr_data = d; bus1.data_rqst = rq; bus1.flush = fl; bus1.err_clr = ec;
    @(posedge clk);
    #1;
    bus0.wr_en = 0; bus0.wr_data = '0; bus0.data_rqst = 0; bus0.flush = 0; bus0.err_clr = 0;
    bus1.wr_en = 0; bus1.wr_data = '0; bus1.data_rqst = 0; bus1.flush = 0; bus1.err_clr = 0;
  endtask

  task automatic writePair(input logic [31:0] l, input logic [31:0] r);
    applyStimulus(1'b1, l, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, r, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic popCheck(input string name, input logic [31:0] l, input logic [31:0] r);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput(name, {bus0.data_left, bus0.data_right}, {l, r});
  endtask

  task automatic checkLevel(input string name, input logic [3:0] exp);
    checkOutput(name, {60'd0, bus0.level}, {60'd0, exp});
  endtask

  task automatic checkFlags(input string name, input logic full, input logic empty,
                            input logic lowWm, input logic ovf, input logic ur);
    checkOutput(name, {59'd0, bus0.full, bus0.empty, bus0.low_wm, bus0.overflow, bus0.underrun},
                {59'd0, full, empty, lowWm, ovf, ur});
  endtask

  vec_t vecs[7];

  initial begin
    logic [31:0] l, r;
    logic [63:0] e;

    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #7 rst = 1'b0;
    @(posedge clk); #1;

    checkLevel("reset_level", 4'd0);
    checkFlags("reset_flags", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("reset_data", {bus0.data_left, bus0.data_right}, 64'd0);

    vecs[0] = '{OP_WR,  32'hA0A0_0001, 4'd0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{OP_WR,  32'hB0B0_0001, 4'd1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[2] = '{OP_WR,  32'hA0A0_0002, 4'd1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{OP_WR,  32'hB0B0_0002, 4'd2, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[4] = '{OP_RQ,  32'h0,         4'd1, 1'b0, 1'b1, 1'b1, 32'hA0A0_0001, 32'hB0B0_0001};
    vecs[5] = '{OP_NOP, 32'h0,         4'd1, 1'b0, 1'b1, 1'b1, 32'hA0A0_0001, 32'hB0B0_0001};
    vecs[6] = '{OP_RQ,  32'h0,         4'd0, 1'b1, 1'b1, 1'b1, 32'hA0A0_0002, 32'hB0B0_0002};

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].op == OP_WR, vecs[i].data, vecs[i].op == OP_RQ, 1'b0, 1'b0);
      checkOutput($sformatf("vec%0d_level", i), {60'd0, bus0.level}, {60'd0, vecs[i].expLevel});
      checkOutput($sformatf("vec%0d_empty_lowwm", i), {62'd0, bus0.empty, bus0.low_wm},
                  {62'd0, vecs[i].expEmpty, vecs[i].expLowWm});
      if (vecs[i].chkData)
        checkOutput($sformatf("vec%0d_data", i), {bus0.data_left, bus0.data_right},
                    {vecs[i].expLeft, vecs[i].expRight});
    end

    // Fill, overflow and drain in order.
    for (int i = 0; i < 8; i++) writePair(32'h1000_0000 + i, 32'h2000_0000 + i);
    checkLevel("fill_level", 4'd8);
    checkFlags("fill_flags", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    writePair(32'hDEAD_0001, 32'hDEAD_0002);
    checkLevel("ovf_level", 4'd8);
    checkFlags("ovf_flags", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) popCheck($sformatf("drain%0d", i), 32'h1000_0000 + i, 32'h2000_0000 + i);
    checkLevel("drain_level", 4'd0);

    // Underrun: muted instance goes to zero, repeating instance keeps pair 7.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("ur_mute_data", {bus0.data_left, bus0.data_right}, 64'd0);
    checkOutput("ur_hold_data", {bus1.data_left, bus1.data_right}, {32'h1000_0007, 32'h2000_0007});
    checkFlags("ur_flags", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkLevel("ur_level", 4'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
    checkOutput("clr_vs_set_ur", {63'd0, bus0.underrun}, 64'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkFlags("err_clr_flags", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Commit and pop together when full, then when empty.
    for (int i = 0; i < 8; i++) writePair(32'h3000_0000 + i, 32'h4000_0000 + i);
    applyStimulus(1'b1, 32'h3000_0008, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h4000_0008, 1'b1, 1'b0, 1'b0);
    checkLevel("full_cp_level", 4'd8);
    checkFlags("full_cp_flags", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("full_cp_data", {bus0.data_left, bus0.data_right}, {32'h3000_0000, 32'h4000_0000});
    for (int i = 1; i < 9; i++) popCheck($sformatf("cp_drain%0d", i), 32'h3000_0000 + i, 32'h4000_0000 + i);
    applyStimulus(1'b1, 32'h5555_0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h6666_0001, 1'b1, 1'b0, 1'b0);
    checkLevel("empty_cp_level", 4'd1);
    checkFlags("empty_cp_flags", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("empty_cp_data", {bus0.data_left, bus0.data_right}, 64'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    popCheck("empty_cp_pop", 32'h5555_0001, 32'h6666_0001);

    // Half pair then flush (also colliding with a write); sticky flag survives.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h7777_0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h7777_0001, 1'b1, 1'b1, 1'b0);
    checkLevel("flush_level", 4'd0);
    checkOutput("flush_data", {bus0.data_left, bus0.data_right}, 64'd0);
    checkOutput("flush_keeps_ur", {63'd0, bus0.underrun}, 64'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    writePair(32'hAAAA_0000, 32'hBBBB_0000);
    checkLevel("post_flush_level", 4'd1);
    popCheck("post_flush_pair", 32'hAAAA_0000, 32'hBBBB_0000);

    // Mid-stream asynchronous reset at level 5.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) writePair(32'hC000_0000 + i, 32'hD000_0000 + i);
    popCheck("pre_rst_pop", 32'hC000_0000, 32'hD000_0000);
    writePair(32'hC000_0005, 32'hD000_0005);
    checkLevel("pre_rst_level", 4'd5);
    #2 rst = 1'b1;
    #1;
    checkLevel("rst_level", 4'd0);
    checkFlags("rst_flags", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_data", {bus0.data_left, bus0.data_right}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Random pairs against a queue scoreboard, wrapping the pointers.
    for (int n = 0; n < 20; n++) begin
      if (sbQ.size() == 8 || (sbQ.size() > 0 && $urandom_range(0, 1) == 1)) begin
        e = sbQ.pop_front();
        popCheck($sformatf("rand_pop%0d", n), e[63:32], e[31:0]);
      end
      l = $urandom;
      r = $urandom;
      writePair(l, r);
      sbQ.push_back({l, r});
      checkLevel($sformatf("rand_level%0d", n), 4'(sbQ.size()));
    end
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      popCheck("rand_drain", e[63:32], e[31:0]);
    end
    checkFlags("rand_end_flags", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
